occupancy_grid_arbiter: RTL and testbench

//  Owns the single port of the occupancy-grid RAM and shares it between three users:
//  - the clear engine (zero sweep),
//  - Bresenham cell updates (log-odds read-modify-write),
//  - VGA pixel reads.

---
 rtl/occupancy_pkg.sv | 21 ++
 rtl/occupancy_grid_arbiter_if.sv | 36 +++
 rtl/log_odds_update.sv | 41 ++++
 rtl/occupancy_grid_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_occupancy_grid_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/occupancy_pkg.sv
// Shared occupancy-grid types: signed log-odds cell, arbiter FSM states and saturation limits.
// Also used by the VGA colour mapper.
package occupancy_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned STAT_WIDTH = 16;

    typedef logic signed [DATA_WIDTH-1:0] cell_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RD,
        MOD,
        WR
    } arb_state_t;

    localparam cell_t LOG_ODDS_MAX = cell_t'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam cell_t LOG_ODDS_MIN = -LOG_ODDS_MAX;

endpackage

// File: rtl/occupancy_grid_arbiter_if.sv
// Request/response bundle between the SLAM control, Bresenham datapath, VGA reader, grid RAM and the arbiter.
// The slave modport is the arbiter's view; the master modport is its clients' view.
interface occupancy_grid_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 14
) ();
    import occupancy_pkg::*;

    logic                  clear_start;
    logic                  occupancy_busy;
    logic                  upd_valid;
    logic                  upd_ready;
    logic [ADDR_WIDTH-1:0] upd_addr;
    logic                  upd_hit;
    logic                  vga_req;
    logic [ADDR_WIDTH-1:0] vga_addr;
    logic                  vga_rdata_valid;
    cell_t                 vga_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    cell_t                 mem_wdata;
    cell_t                 mem_rdata;
    logic [STAT_WIDTH-1:0] stall_cycles;

    modport slave (
        input  clear_start, upd_valid, upd_addr, upd_hit, vga_req, vga_addr, mem_rdata,
        output occupancy_busy, upd_ready, vga_rdata_valid, vga_rdata,
               mem_addr, mem_we, mem_wdata, stall_cycles
    );

    modport master (
        output clear_start, upd_valid, upd_addr, upd_hit, vga_req, vga_addr, mem_rdata,
        input  occupancy_busy, upd_ready, vga_rdata_valid, vga_rdata,
               mem_addr, mem_we, mem_wdata, stall_cycles
    );

endinterface

// File: rtl/log_odds_update.sv
// Combinational saturating log-odds step: +HIT_INC on a hit, -MISS_DEC on a miss, clamped to +/-LOG_ODDS_MAX.
module log_odds_update
    import occupancy_pkg::*;
#(
    parameter int unsigned HIT_INC  = 3,
    parameter int unsigned MISS_DEC = 1
) (
    input  cell_t i_v,
    input  logic  i_hit,
    output cell_t o_v_c
);
    localparam int unsigned WW = DATA_WIDTH + 1;
    localparam cell_t RAW_MIN = LOG_ODDS_MIN - cell_t'(1);
    localparam logic signed [WW-1:0] W_MAX = {LOG_ODDS_MAX[DATA_WIDTH-1], LOG_ODDS_MAX};
    localparam logic signed [WW-1:0] W_MIN = {LOG_ODDS_MIN[DATA_WIDTH-1], LOG_ODDS_MIN};

    logic signed [WW-1:0] w_base;
    logic signed [WW-1:0] w_inc;
    logic signed [WW-1:0] w_dec;
    logic signed [WW-1:0] w_sum;

    assign w_inc = WW'(HIT_INC);
    assign w_dec = WW'(MISS_DEC);

    // The asymmetric most-negative code is folded onto MIN before the step.
    always_comb begin
        w_base = {i_v[DATA_WIDTH-1], i_v};
        if (i_v == RAW_MIN) begin
            w_base = W_MIN;
        end
        w_sum = i_hit ? (w_base + w_inc) : (w_base - w_dec);
        if (w_sum > W_MAX) begin
            o_v_c = LOG_ODDS_MAX;
        end else if (w_sum < W_MIN) begin
            o_v_c = LOG_ODDS_MIN;
        end else begin
            o_v_c = cell_t'(w_sum);
        end
    end

endmodule

// File: rtl/occupancy_grid_arbiter.sv
// Single-port grid RAM arbiter: VGA reads pre-empt the clear sweep and log-odds read-modify-write.
// Optional stall statistics counter built when OCC_ARB_STATS_EN is defined.
module occupancy_grid_arbiter
    import occupancy_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned HIT_INC    = 3,
    parameter int unsigned MISS_DEC   = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    occupancy_grid_arbiter_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clear_addr;
    logic [ADDR_WIDTH-1:0] w_clear_addr_nxt;
    logic                  r_clear_pending;
    logic                  w_clear_pending_nxt;
    logic [ADDR_WIDTH-1:0] r_upd_addr;
    logic                  r_upd_hit;
    cell_t                 r_new_val;
    logic                  r_vga_valid;
    logic                  w_port_use;
    logic                  w_stall;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_upd_ready;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic                  w_mem_we;
    cell_t                 w_mem_wdata;
    cell_t                 w_lo_val;

    assign w_port_use = (r_state == CLEAR) || (r_state == RD) || (r_state == WR);
    assign w_stall    = bus.vga_req && w_port_use;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and RAM port mux; port outputs are combinational so a VGA read returns next cycle.
    always_comb begin
        w_state_nxt         = r_state;
        w_clear_addr_nxt    = r_clear_addr;
        w_clear_pending_nxt = r_clear_pending;
        w_accept            = 1'b0;
        w_capture           = 1'b0;
        w_upd_ready         = 1'b0;
        w_mem_addr          = '0;
        w_mem_we            = 1'b0;
        w_mem_wdata         = '0;

        case (r_state)
            IDLE: begin
                w_upd_ready = !bus.clear_start;
                if (bus.clear_start || r_clear_pending) begin
                    w_state_nxt         = CLEAR;
                    w_clear_addr_nxt    = '0;
                    w_clear_pending_nxt = 1'b0;
                end else if (bus.upd_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RD;
                end
            end
            CLEAR: begin
                w_mem_addr = r_clear_addr;
                w_mem_we   = 1'b1;
                if (bus.clear_start) begin
                    w_clear_addr_nxt = '0;
                end else if (!w_stall) begin
                    if (r_clear_addr == LAST_ADDR) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_clear_addr_nxt = r_clear_addr + ADDR_WIDTH'(1);
                    end
                end
            end
            RD: begin
                w_mem_addr = r_upd_addr;
                if (bus.clear_start) begin
                    w_clear_pending_nxt = 1'b1;
                end
                if (!w_stall) begin
                    w_state_nxt = MOD;
                end
            end
            MOD: begin
                w_capture   = 1'b1;
                w_state_nxt = WR;
                if (bus.clear_start) begin
                    w_clear_pending_nxt = 1'b1;
                end
            end
            WR: begin
                w_mem_addr  = r_upd_addr;
                w_mem_we    = 1'b1;
                w_mem_wdata = r_new_val;
                if (bus.clear_start) begin
                    w_clear_pending_nxt = 1'b1;
                end
                // A clear requested during the RMW starts as soon as the write retires.
                if (!w_stall) begin
                    if (r_clear_pending || bus.clear_start) begin
                        w_state_nxt         = CLEAR;
                        w_clear_addr_nxt    = '0;
                        w_clear_pending_nxt = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (bus.vga_req) begin
            w_mem_addr = bus.vga_addr;
            w_mem_we   = 1'b0;
        end

        // Keep the RAM port quiet while reset is asserted.
        if (!reset_n) begin
            w_mem_addr  = '0;
            w_mem_we    = 1'b0;
            w_mem_wdata = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_clear_addr    <= '0;
            r_clear_pending <= 1'b0;
            r_upd_addr      <= '0;
            r_upd_hit       <= 1'b0;
            r_new_val       <= '0;
            r_vga_valid     <= 1'b0;
        end else begin
            r_clear_addr    <= w_clear_addr_nxt;
            r_clear_pending <= w_clear_pending_nxt;
            r_vga_valid     <= bus.vga_req;
            if (w_accept) begin
                r_upd_addr <= bus.upd_addr;
                r_upd_hit  <= bus.upd_hit;
            end
            if (w_capture) begin
                r_new_val <= w_lo_val;
            end
        end
    end

    log_odds_update #(
        .HIT_INC (HIT_INC),
        .MISS_DEC(MISS_DEC)
    ) u_log_odds_update (
        .i_v  (bus.mem_rdata),
        .i_hit(r_upd_hit),
        .o_v_c(w_lo_val)
    );

`ifdef OCC_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] r_stall_cycles;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (bus.clear_start) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + STAT_WIDTH'(1);
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`else
    assign bus.stall_cycles = '0;
`endif

    assign bus.mem_addr        = w_mem_addr;
    assign bus.mem_we          = w_mem_we;
    assign bus.mem_wdata       = w_mem_wdata;
    assign bus.upd_ready       = w_upd_ready;
    assign bus.occupancy_busy  = (r_state != IDLE) || r_clear_pending;
    assign bus.vga_rdata_valid = r_vga_valid;
    assign bus.vga_rdata       = bus.mem_rdata;

endmodule

// File: tb/tb_occupancy_grid_arbiter.sv
// Scoreboard bench for occupancy_grid_arbiter with a 16-cell RAM model and a log-odds reference model.
module tb_occupancy_grid_arbiter;
    import occupancy_pkg::*;

    localparam int unsigned AW = 4;
    localparam int NCELL = 16;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    occupancy_grid_arbiter_if #(.ADDR_WIDTH(AW)) ifc ();

    occupancy_grid_arbiter #(
        .ADDR_WIDTH(AW),
        .HIT_INC   (3),
        .MISS_DEC  (1)
    ) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    // RAM model with a backdoor preload port and 1-cycle read latency
    cell_t ram [NCELL];
    cell_t ram_q = '0;
    logic pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    cell_t pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (ifc.mem_we) ram[ifc.mem_addr] <= ifc.mem_wdata;
        ram_q <= ram[ifc.mem_addr];
    end
    assign ifc.mem_rdata = ram_q;

    int n_checks = 0;
    int n_fail = 0;
    int ref_grid [NCELL];
    wr_t wq[$];
    int vq[$];
    int busy_addr = -1;
    int vga_mode = 0;
    logic vga_dir_req = 1'b0;
    int vga_dir_addr = 0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int ref_update(int v, bit hit);
        int r;
        int base;
        base = (v < -127) ? -127 : v;
        r = hit ? base + 3 : base - 1;
        if (r > 127) r = 127;
        if (r < -127) r = -127;
        return r;
    endfunction

    // Monitor: pop and compare whenever the DUT writes or returns VGA data
    always @(negedge clk) begin : mon
        wr_t w;
        int v;
        if (rst_n) begin
            if (ifc.mem_we === 1'b1) begin
                if (wq.size() == 0) check("unexpected_write", 1, 0);
                else begin
                    w = wq.pop_front();
                    check("wr_addr", int'(ifc.mem_addr), w.addr);
                    check("wr_data", int'(ifc.mem_wdata), w.data);
                end
            end
            if (ifc.vga_rdata_valid === 1'b1) begin
                if (vq.size() == 0) check("unexpected_vga", 1, 0);
                else begin
                    v = vq.pop_front();
                    check("vga_rdata", int'(ifc.vga_rdata), v);
                end
            end
        end
    end

    // Single VGA driver; acts 2 time units after the edge so main-process settings land first
    initial begin : vga_drv
        int a;
        ifc.vga_req = 1'b0;
        ifc.vga_addr = '0;
        forever begin
            @(posedge clk);
            #2;
            if (vga_mode == 1 && $urandom_range(0, 2) == 0) begin
                do a = int'($urandom_range(0, NCELL - 1)); while (a == busy_addr);
                ifc.vga_req = 1'b1;
                ifc.vga_addr = AW'(a);
                vq.push_back(ref_grid[a]);
            end else if (vga_mode == 2 && vga_dir_req) begin
                ifc.vga_req = 1'b1;
                ifc.vga_addr = AW'(vga_dir_addr);
                vq.push_back(ref_grid[vga_dir_addr]);
            end else begin
                ifc.vga_req = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic preload(input int a, input int v);
        @(posedge clk); #1;
        pre_we = 1'b1;
        pre_addr = AW'(a);
        pre_data = cell_t'(v);
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_grid[a] = v;
    endtask

    task automatic push_clear();
        for (int i = 0; i < NCELL; i++) begin
            wq.push_back('{i, 0});
            ref_grid[i] = 0;
        end
    endtask

    task automatic do_update(input int a, input bit hit, input bit chk_ready);
        int n;
        int e;
        @(posedge clk); #1;
        busy_addr = a;
        ifc.upd_valid = 1'b1;
        ifc.upd_addr = AW'(a);
        ifc.upd_hit = hit;
        n = 0;
        @(negedge clk);
        while (!ifc.upd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check("upd_accept_timeout", 1, 0);
            ifc.upd_valid = 1'b0;
            busy_addr = -1;
            return;
        end
        e = ref_update(ref_grid[a], hit);
        ref_grid[a] = e;
        wq.push_back('{a, e});
        @(posedge clk); #1;
        ifc.upd_valid = 1'b0;
        if (chk_ready) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("upd_ready_low", int'(ifc.upd_ready), 0);
            end
            @(negedge clk);
            check("upd_ready_back", int'(ifc.upd_ready), 1);
        end
        n = 0;
        while (ifc.occupancy_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("busy_timeout", 1, 0);
        busy_addr = -1;
    endtask

    initial begin : main
        int e;
        int exp_stall;
        ifc.clear_start = 1'b0;
        ifc.upd_valid = 1'b0;
        ifc.upd_addr = '0;
        ifc.upd_hit = 1'b0;
        for (int i = 0; i < NCELL; i++) ref_grid[i] = 0;
        push_clear();

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", int'(ifc.mem_we), 0);
        check("rst_mem_addr", int'(ifc.mem_addr), 0);
        check("rst_mem_wdata", int'(ifc.mem_wdata), 0);
        check("rst_vga_valid", int'(ifc.vga_rdata_valid), 0);
        check("rst_upd_ready", int'(ifc.upd_ready), 0);
        check("rst_busy", int'(ifc.occupancy_busy), 1);
        check("rst_stall", int'(ifc.stall_cycles), 0);

        // 1: reset sweep on consecutive cycles
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < NCELL; i++) begin
            @(negedge clk);
            check("t1_clr_we", int'(ifc.mem_we), 1);
            check("t1_clr_addr", int'(ifc.mem_addr), i);
            check("t1_busy_during", int'(ifc.occupancy_busy), 1);
        end
        @(negedge clk);
        check("t1_busy_fall", int'(ifc.occupancy_busy), 0);
        check("t1_ready_idle", int'(ifc.upd_ready), 1);

        // 2: saturation at MAX
        preload(5, 125);
        do_update(5, 1'b1, 1'b1);
        do_update(5, 1'b1, 1'b1);

        // 3: miss toward MIN, including the -128 code
        preload(2, 0);
        preload(3, -127);
        preload(4, -128);
        do_update(2, 1'b0, 1'b1);
        do_update(3, 1'b0, 1'b1);
        do_update(4, 1'b0, 1'b1);

        // 4: VGA holds RD for 5 cycles
        for (int i = 0; i < 5; i++) preload(10 + i, i * 37 - 70);
        vga_mode = 2;
        @(posedge clk); #1;
        ifc.upd_valid = 1'b1;
        ifc.upd_addr = AW'(9);
        ifc.upd_hit = 1'b1;
        @(negedge clk);
        check("t4_ready", int'(ifc.upd_ready), 1);
        e = ref_update(ref_grid[9], 1'b1);
        ref_grid[9] = e;
        wq.push_back('{9, e});
        @(posedge clk); #1;
        ifc.upd_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            vga_dir_req = (c < 5);
            vga_dir_addr = 10 + (c % 5);
            @(negedge clk);
            check("t4_mem_we", int'(ifc.mem_we), int'(c == 7));
            check("t4_vga_valid", int'(ifc.vga_rdata_valid), int'(c >= 1 && c <= 5));
            check("t4_upd_ready", int'(ifc.upd_ready), 0);
            if (c != 7) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        check("t4_busy_fall", int'(ifc.occupancy_busy), 0);
`ifdef OCC_ARB_STATS_EN
        exp_stall = 5;
`else
        exp_stall = 0;
`endif
        check("t4_stall_cycles", int'(ifc.stall_cycles), exp_stall);

        // 5: clear_start during MOD
        @(posedge clk); #1;
        ifc.upd_valid = 1'b1;
        ifc.upd_addr = AW'(6);
        ifc.upd_hit = 1'b1;
        @(negedge clk);
        check("t5_ready", int'(ifc.upd_ready), 1);
        e = ref_update(ref_grid[6], 1'b1);
        wq.push_back('{6, e});
        push_clear();
        @(posedge clk); #1;
        ifc.upd_valid = 1'b0;
        @(posedge clk); #1;
        ifc.clear_start = 1'b1;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            if (c < 18) begin
                check("t5_busy", int'(ifc.occupancy_busy), 1);
                check("t5_ready_low", int'(ifc.upd_ready), 0);
                check("t5_mem_we", int'(ifc.mem_we), int'(c >= 1));
                if (c >= 1) check("t5_mem_addr", int'(ifc.mem_addr), (c == 1) ? 6 : c - 2);
            end else begin
                check("t5_busy_fall", int'(ifc.occupancy_busy), 0);
            end
            @(posedge clk); #1;
            ifc.clear_start = 1'b0;
        end
        check("t5_stall_zeroed", int'(ifc.stall_cycles), 0);

        // 6: VGA sees the updated cell
        do_update(7, 1'b1, 1'b1);
        @(posedge clk); #1;
        vga_dir_req = 1'b1;
        vga_dir_addr = 7;
        @(posedge clk); #1;
        vga_dir_req = 1'b0;
        @(negedge clk);
        check("t6_vga_valid", int'(ifc.vga_rdata_valid), 1);
        check("t6_vga_rdata", int'(ifc.vga_rdata), 3);
        vga_mode = 0;

        // Random updates with random VGA traffic
        for (int i = 0; i < NCELL; i++) preload(i, int'($urandom_range(0, 255)) - 128);
        vga_mode = 1;
        for (int i = 0; i < 60; i++) begin
            do_update(int'($urandom_range(0, NCELL - 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        vga_mode = 0;
        repeat (4) @(negedge clk);
        check("wq_drained", wq.size(), 0);
        check("vq_drained", vq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
